// File: rtl/dlx_mem_access.sv
// dlx_mem_access: memory-access stage after the ALU.
// Routes arithmetic results to writeback, runs req/ack data memory cycles.
module dlx_mem_access #(
    parameter int         TIMEOUT   = 16,
    parameter logic [2:0] SEL_ARITH = 3'b001,
    parameter logic [2:0] SEL_LOAD  = 3'b101,
    parameter logic [2:0] SEL_STORE = 3'b110
) (
    input  logic        clk2,
    input  logic        rst2,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  alusel,
    input  logic [2:0]  aluop,
    input  logic [31:0] alu_result,
    input  logic        carry_in,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        carry_flag,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [4:0]  ld_rd,
    output logic        err_misalign,
    output logic        err_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [4:0]    acc_rd;
    logic          accept, is_mem, misalign, start_acc, acc_end;
    logic          is_byte, is_half;
    logic [3:0]    be_nxt;
    logic [31:0]   wdata_nxt;

    assign accept    = in_valid && in_ready;
    assign is_mem    = (alusel == SEL_LOAD) || (alusel == SEL_STORE);
    assign start_acc = accept && is_mem && !misalign;
    assign acc_end   = dmem_ack || (cnt == LAST);

    // Decode access size from the ALU size code.
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        case (aluop)
            3'b000, 3'b100: is_byte = 1'b1;
            3'b001, 3'b101: is_half = 1'b1;
            default: ;
        endcase
    end

    // Alignment check: halves need bit0 clear, words need bits[1:0] clear.
    always_comb begin
        misalign = 1'b0;
        unique case (1'b1)
            is_byte: misalign = 1'b0;
            is_half: misalign = alu_result[0];
            default: misalign = |alu_result[1:0];
        endcase
    end

    // Little-endian lane placement; loads always fetch the full word.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = store_data;
        if (alusel == SEL_STORE) begin
            unique case (1'b1)
                is_byte: begin
                    be_nxt    = 4'b0001 << alu_result[1:0];
                    wdata_nxt = {4{store_data[7:0]}};
                end
                is_half: begin
                    be_nxt    = alu_result[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        dmem_req  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (start_acc) state_nxt = ACCESS;
            end
            ACCESS: begin
                dmem_req = 1'b1;
                if (acc_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers, pulse outputs and access counter.
    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            cnt          <= '0;
            acc_rd       <= '0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            wb_en        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            carry_flag   <= 1'b0;
            ld_valid     <= 1'b0;
            ld_data      <= '0;
            ld_rd        <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            wb_en        <= 1'b0;
            ld_valid     <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            if (accept && alusel == SEL_ARITH) begin
                wb_en      <= (rd != 5'd0);
                wb_rd      <= rd;
                wb_data    <= alu_result;
                carry_flag <= carry_in;
            end
            if (accept && is_mem && misalign) err_misalign <= 1'b1;
            if (start_acc) begin
                dmem_we    <= (alusel == SEL_STORE);
                dmem_addr  <= {alu_result[31:2], 2'b00};
                dmem_wdata <= wdata_nxt;
                dmem_be    <= be_nxt;
                acc_rd     <= rd;
                cnt        <= '0;
            end
            if (state == ACCESS) begin
                if (dmem_ack) begin
                    if (!dmem_we) begin
                        ld_valid <= 1'b1;
                        ld_data  <= dmem_rdata;
                        ld_rd    <= acc_rd;
                    end
                end else if (cnt == LAST) begin
                    err_timeout <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dlx_mem_access.sv
// tb_dlx_mem_access: scoreboard bench for the memory-access stage.
// Expected events are queued by stimulus and popped by a negedge monitor.
module tb_dlx_mem_access;

    logic        clk2 = 1'b0;
    logic        rst2 = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alusel = '0;
    logic [2:0]  aluop = '0;
    logic [31:0] alu_result = '0;
    logic        carry_in = 1'b0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        carry_flag, ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        err_misalign, err_timeout;

    dlx_mem_access dut (
        .clk2(clk2), .rst2(rst2), .in_valid(in_valid), .in_ready(in_ready),
        .alusel(alusel), .aluop(aluop), .alu_result(alu_result),
        .carry_in(carry_in), .store_data(store_data), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .carry_flag(carry_flag), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_rd(ld_rd), .err_misalign(err_misalign),
        .err_timeout(err_timeout)
    );

    always #5 clk2 = ~clk2;

    localparam logic [2:0] A = 3'b001;
    localparam logic [2:0] L = 3'b101;
    localparam logic [2:0] S = 3'b110;

    typedef enum int {K_REQ, K_LEN, K_WB, K_LD, K_MIS, K_TMO} kind_t;
    typedef struct {
        kind_t       k;
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  r;
        logic        c;
        logic [3:0]  be;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic get(kind_t k, output ev_t e, output bit ok);
        n_cmp++;
        ok = 1'b0;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL event: got unexpected %s want none", k.name());
        end else begin
            e = q.pop_front();
            if (e.k != k) begin
                n_err++;
                $display("FAIL event: got %s want %s", k.name(), e.k.name());
            end else ok = 1'b1;
        end
    endtask

    function automatic ev_t mk(kind_t k, logic [31:0] a, logic [31:0] d,
                               logic [4:0] r, logic c, logic [3:0] be);
        ev_t e;
        e.k = k; e.a = a; e.d = d; e.r = r; e.c = c; e.be = be;
        return e;
    endfunction

    // Monitor: pops an expectation for every observable DUT event.
    bit prev_req = 1'b0;
    int req_len = 0;
    always @(negedge clk2) begin
        ev_t e;
        bit  ok;
        if (rst2) begin
            prev_req = 1'b0;
            req_len  = 0;
        end else begin
            if (dmem_req && !prev_req) begin
                get(K_REQ, e, ok);
                if (ok) begin
                    chk("req_addr", dmem_addr, e.a);
                    chk("req_we", 32'(dmem_we), 32'(e.c));
                    chk("req_be", 32'(dmem_be), 32'(e.be));
                    if (e.c) chk("req_wdata", dmem_wdata, e.d);
                end
            end
            if (dmem_req) req_len++;
            if (!dmem_req && prev_req) begin
                get(K_LEN, e, ok);
                if (ok) chk("req_len", 32'(req_len), e.a);
                req_len = 0;
            end
            prev_req = dmem_req;
            if (wb_en) begin
                get(K_WB, e, ok);
                if (ok) begin
                    chk("wb_rd", 32'(wb_rd), 32'(e.r));
                    chk("wb_data", wb_data, e.d);
                    chk("carry_flag", 32'(carry_flag), 32'(e.c));
                end
            end
            if (ld_valid) begin
                get(K_LD, e, ok);
                if (ok) begin
                    chk("ld_data", ld_data, e.d);
                    chk("ld_rd", 32'(ld_rd), 32'(e.r));
                end
            end
            if (err_misalign) get(K_MIS, e, ok);
            if (err_timeout) get(K_TMO, e, ok);
        end
    end

    task automatic drive(logic [2:0] s, logic [2:0] op, logic [31:0] a,
                         logic [31:0] sd, logic [4:0] r, logic c);
        alusel = s; aluop = op; alu_result = a;
        store_data = sd; rd = r; carry_in = c;
        in_valid = 1'b1;
    endtask

    task automatic send(logic [2:0] s, logic [2:0] op, logic [31:0] a,
                        logic [31:0] sd, logic [4:0] r, logic c);
        drive(s, op, a, sd, r, c);
        @(negedge clk2);
        in_valid = 1'b0;
    endtask

    // Ack sampled on the k-th cycle of the request.
    task automatic ack_on(int k, logic [31:0] rdv);
        repeat (k - 1) @(negedge clk2);
        dmem_ack = 1'b1;
        dmem_rdata = rdv;
        @(negedge clk2);
        dmem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        #1 rst2 = 1'b1;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_ld_valid", 32'(ld_valid), 32'd0);
        chk("rst_carry", 32'(carry_flag), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        repeat (2) @(posedge clk2);
        #2 rst2 = 1'b0;
        @(negedge clk2);

        q.push_back(mk(K_WB, 0, 32'h0000_1234, 5'd5, 1'b1, 0));
        send(A, 3'b011, 32'h0000_1234, 0, 5'd5, 1'b1);
        send(A, 3'b011, 32'h0000_5678, 0, 5'd0, 1'b1);
        chk("wb_en_rd0", 32'(wb_en), 32'd0);

        q.push_back(mk(K_WB, 0, 32'hAAAA_0001, 5'd3, 1'b0, 0));
        q.push_back(mk(K_WB, 0, 32'h5555_0002, 5'd4, 1'b1, 0));
        drive(A, 3'b011, 32'hAAAA_0001, 0, 5'd3, 1'b0);
        @(negedge clk2);
        drive(A, 3'b011, 32'h5555_0002, 0, 5'd4, 1'b1);
        @(negedge clk2);
        in_valid = 1'b0;
        @(negedge clk2);

        q.push_back(mk(K_REQ, 32'h100, 32'hABABABAB, 0, 1'b1, 4'b1000));
        q.push_back(mk(K_LEN, 32'd3, 0, 0, 0, 0));
        send(S, 3'b000, 32'h103, 32'h0000_00AB, 5'd0, 1'b0);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        ack_on(3, 0);
        chk("done_in_ready", 32'(in_ready), 32'd1);

        q.push_back(mk(K_REQ, 32'h10, 32'h56785678, 0, 1'b1, 4'b1100));
        q.push_back(mk(K_LEN, 32'd1, 0, 0, 0, 0));
        send(S, 3'b001, 32'h12, 32'h1234_5678, 5'd0, 1'b0);
        ack_on(1, 0);

        q.push_back(mk(K_REQ, 32'h40, 32'h11111111, 0, 1'b1, 4'b0001));
        q.push_back(mk(K_LEN, 32'd1, 0, 0, 0, 0));
        send(S, 3'b100, 32'h40, 32'h0000_0011, 5'd0, 1'b0);
        ack_on(1, 0);

        q.push_back(mk(K_REQ, 32'h200, 0, 0, 1'b0, 4'b1111));
        q.push_back(mk(K_LEN, 32'd2, 0, 0, 0, 0));
        q.push_back(mk(K_LD, 0, 32'hDEADBEEF, 5'd12, 0, 0));
        send(L, 3'b011, 32'h200, 0, 5'd12, 1'b0);
        ack_on(2, 32'hDEADBEEF);

        q.push_back(mk(K_MIS, 0, 0, 0, 0, 0));
        send(L, 3'b001, 32'h201, 0, 5'd2, 1'b0);
        @(negedge clk2);
        q.push_back(mk(K_MIS, 0, 0, 0, 0, 0));
        send(S, 3'b011, 32'h2, 0, 5'd0, 1'b0);
        @(negedge clk2);

        send(3'b010, 3'b011, 32'h300, 0, 5'd9, 1'b0);
        chk("other_in_ready", 32'(in_ready), 32'd1);
        chk("other_wb_en", 32'(wb_en), 32'd0);

        q.push_back(mk(K_REQ, 32'h400, 32'hCAFEF00D, 0, 1'b1, 4'b1111));
        q.push_back(mk(K_LEN, 32'd16, 0, 0, 0, 0));
        q.push_back(mk(K_TMO, 0, 0, 0, 0, 0));
        send(S, 3'b011, 32'h400, 32'hCAFEF00D, 5'd0, 1'b0);
        repeat (18) @(negedge clk2);
        chk("tmo_in_ready", 32'(in_ready), 32'd1);

        q.push_back(mk(K_REQ, 32'h404, 32'h0BADF00D, 0, 1'b1, 4'b1111));
        q.push_back(mk(K_LEN, 32'd16, 0, 0, 0, 0));
        send(S, 3'b011, 32'h404, 32'h0BADF00D, 5'd0, 1'b0);
        ack_on(16, 0);
        chk("ack16_tmo", 32'(err_timeout), 32'd0);
        chk("ack16_in_ready", 32'(in_ready), 32'd1);

        q.push_back(mk(K_REQ, 32'h200, 0, 0, 1'b0, 4'b1111));
        q.push_back(mk(K_LEN, 32'd1, 0, 0, 0, 0));
        q.push_back(mk(K_LD, 0, 32'h12345678, 5'd1, 0, 0));
        send(L, 3'b100, 32'h203, 0, 5'd1, 1'b0);
        ack_on(1, 32'h12345678);

        q.push_back(mk(K_REQ, 32'h300, 0, 0, 1'b0, 4'b1111));
        send(L, 3'b011, 32'h300, 0, 5'd7, 1'b0);
        @(posedge clk2);
        #2 rst2 = 1'b1;
        #1;
        chk("arst_req", 32'(dmem_req), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk2);
        @(posedge clk2);
        #2 rst2 = 1'b0;
        @(negedge clk2);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0000_0077;
        repeat (2) @(negedge clk2);
        dmem_ack = 1'b0;
        chk("late_ack_ld", 32'(ld_valid), 32'd0);
        chk("late_ack_req", 32'(dmem_req), 32'd0);

        repeat (3) @(negedge clk2);
        chk("queue_left", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
